div_scheduler: RTL

- Shares one iterative divider among `size` reservation-station entries. This replaces one divider per entry.
- Accepts DIV/DIVU/REM/REMU requests and picks one per operation by round-robin.
- Does the RISC-V sign handling, divide-by-zero and overflow handling around an unsigned divider.
- Broadcasts the result with its ROB tag for one cycle. Sits between the RS/ALU issue logic and the `divider` instance.

---
 rtl/div_scheduler_pkg.sv | 30 +++
 rtl/div_scheduler_rr_arbiter.sv | 55 +++++
 rtl/div_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_scheduler_pkg.sv
// Shared types and helpers for the divider scheduler.
//   div_op_t          : RISC-V divide/remainder operation encoding
//   div_sched_state_t : scheduler FSM states
//   is_neg / negate   : two's-complement helpers at XLEN width
package div_scheduler_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_sched_state_t;

    function automatic logic is_neg(input logic [XLEN-1:0] x);
        return x[XLEN-1];
    endfunction

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return (~x) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin picker over `size` requesters.
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : request vector
//   advance  : the current pick is taken; move the pointer past it
//   grant    : one-hot pick (combinational), first set bit at/after pointer
module rr_arbiter #(
    parameter int size = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] req,
    input  logic            advance,
    output logic [size-1:0] grant
);

    localparam int PTR_W = (size > 1) ? $clog2(size) : 1;
    localparam logic [PTR_W:0] SIZE_W = (PTR_W+1)'(size);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   idx_w;
    logic [PTR_W:0]   nxt_w;
    logic             found;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from the pointer, wrapping modulo size; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_w = '0;
        nxt_w = '0;
        for (int k = 0; k < size; k++) begin
            idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx_w >= SIZE_W) begin
                idx_w = idx_w - SIZE_W;
            end
            if (!found && req[idx_w[PTR_W-1:0]]) begin
                found = 1'b1;
                grant[idx_w[PTR_W-1:0]] = 1'b1;
                nxt_w = (idx_w + 1'b1 == SIZE_W) ? '0 : idx_w + 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = nxt_w[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// Shares one unsigned iterative divider among `size` requesters and wraps
// it with RISC-V DIV/DIVU/REM/REMU sign, divide-by-zero and overflow rules.
//   req_*          : per-entry request (valid, op, dividend, divisor, tag)
//   grant          : one-hot accept pulse, only in IDLE
//   div_valid/a/b  : start/hold and unsigned operands to the divider
//   div_quo/rem/rdy: divider result
//   out_valid/data/tag : one-cycle result broadcast
//   flush          : abandon the in-flight operation, keep the RR pointer
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int size      = 15,
    parameter int width     = 32,
    parameter int tag_width = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic    [size-1:0]                   req_valid,
    input  div_op_t [size-1:0]                   req_op,
    input  logic    [size-1:0][width-1:0]        req_r1,
    input  logic    [size-1:0][width-1:0]        req_r2,
    input  logic    [size-1:0][tag_width-1:0]    req_tag,
    output logic    [size-1:0]                   grant,
    output logic                                 div_valid,
    output logic    [width-1:0]                  div_a,
    output logic    [width-1:0]                  div_b,
    input  logic    [width-1:0]                  div_quo,
    input  logic    [width-1:0]                  div_rem,
    input  logic                                 div_rdy,
    output logic                                 out_valid,
    output logic    [width-1:0]                  out_data,
    output logic    [tag_width-1:0]              out_tag
);

    localparam logic [width-1:0] INT_MIN = {1'b1, {(width-1){1'b0}}};

    div_sched_state_t     state_q, state_d;
    div_op_t              op_q, op_d;
    logic [tag_width-1:0] tag_q, tag_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [width-1:0]     a_q, a_d;
    logic [width-1:0]     b_q, b_d;
    logic [width-1:0]     out_data_q, out_data_d;

    logic [size-1:0]      arb_grant;
    logic                 take;
    logic                 any_req;
    div_op_t              sel_op;
    logic [width-1:0]     sel_r1, sel_r2;
    logic [tag_width-1:0] sel_tag;
    logic                 sel_signed, sel_is_rem, sel_sa, sel_sb;

    // A grant is only possible in IDLE and never during flush or reset.
    assign take    = (state_q == IDLE) && !flush && !rst;
    assign any_req = |req_valid;

    rr_arbiter #(.size(size)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (take),
        .grant   (arb_grant)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= DIV;
            tag_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_data_q <= out_data_d;
        end
    end

    // One-hot grant to operand mux.
    always_comb begin
        sel_op  = DIV;
        sel_r1  = '0;
        sel_r2  = '0;
        sel_tag = '0;
        for (int i = 0; i < size; i++) begin
            if (arb_grant[i]) begin
                sel_op  = req_op[i];
                sel_r1  = req_r1[i];
                sel_r2  = req_r2[i];
                sel_tag = req_tag[i];
            end
        end
        sel_signed = (sel_op == DIV) || (sel_op == REM);
        sel_is_rem = (sel_op == REM) || (sel_op == REMU);
        sel_sa     = sel_signed && is_neg(sel_r1);
        sel_sb     = sel_signed && is_neg(sel_r2);
    end

    // Next state and latched operands
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tag_d      = tag_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        a_d        = a_q;
        b_d        = b_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (take && any_req) begin
                    op_d      = sel_op;
                    tag_d     = sel_tag;
                    neg_quo_d = sel_sa ^ sel_sb;
                    neg_rem_d = sel_sa;
                    a_d       = sel_sa ? negate(sel_r1) : sel_r1;
                    b_d       = sel_sb ? negate(sel_r2) : sel_r2;
                    // Results the divider cannot give directly are resolved here.
                    if (sel_r2 == '0) begin
                        out_data_d = sel_is_rem ? sel_r1 : '1;
                        state_d    = DONE;
                    end else if (sel_signed && sel_r1 == INT_MIN && sel_r2 == '1) begin
                        out_data_d = sel_is_rem ? '0 : INT_MIN;
                        state_d    = DONE;
                    end else begin
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (div_rdy) begin
                    case (op_q)
                        DIV:     out_data_d = neg_quo_q ? negate(div_quo) : div_quo;
                        REM:     out_data_d = neg_rem_q ? negate(div_rem) : div_rem;
                        DIVU:    out_data_d = div_quo;
                        default: out_data_d = div_rem;
                    endcase
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        grant     = take ? arb_grant : '0;
        div_valid = (state_q == BUSY);
        div_a     = a_q;
        div_b     = b_q;
        out_valid = (state_q == DONE) && !flush && !rst;
        out_data  = out_data_q;
        out_tag   = tag_q;
    end

endmodule
